// File: rtl/adc_frame_packer_pkg.sv
// Shared types and defaults for the ADC frame packer.
// Frame: HEADER, SEQ, D3, D2, D1, D0, CSUM.
package adc_frame_packer_pkg;

  localparam int         FIFO_AW_DEF = 3;
  localparam logic [7:0] HEADER_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_D3,
    S_D2,
    S_D1,
    S_D0,
    S_CSUM
  } state_e;

  function automatic logic [7:0] csum8(
    input logic [7:0]  seq,
    input logic [31:0] w
  );
    return seq ^ w[31:24] ^ w[23:16]
               ^ w[15:8]  ^ w[7:0];
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample strobe in, byte valid/ready out.
// master is the packer side, slave the ADC/UART side.
interface adc_frame_packer_if;

  logic [31:0] sample_data;
  logic        sample_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  sample_data,
    input  sample_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output sample_data,
    output sample_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/adc_frame_packer_sample_fifo.sv
// Sample FIFO: async clear, distributed-RAM array,
// combinational head read.
module adc_frame_packer_sample_fifo #(
  parameter int AW = 3,
  parameter int W  = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    unique case (1'b1)
      push_i && !pop_i: level_d = level_q + 1'b1;
      pop_i && !push_i: level_d = level_q - 1'b1;
      default:          level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/adc_frame_packer.sv
// Wraps buffered ADC words into 7-byte frames
// for the UART TX byte handshake.
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int         FIFO_AW = FIFO_AW_DEF,
  parameter logic [7:0] HEADER  = HEADER_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  adc_frame_packer_if.master   bus,
  output logic [FIFO_AW:0]     fifo_level_o,
  output logic                 overflow_o,
  output logic [7:0]           drop_count_o,
  input  logic                 clear_ovf_i
);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  seqr_q, seqr_d;
  logic [7:0]  txd_q, txd_d;
  logic        txv_q, txv_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;

  logic        push, pop, drop;
  logic        full, empty, accept;
  logic [31:0] head;

  adc_frame_packer_sample_fifo #(
    .AW (FIFO_AW),
    .W  (32)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.sample_data),
    .rdata_o (head),
    .level_o (fifo_level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // A pop in the same cycle frees a slot for the push.
  assign push   = bus.sample_valid & (~full | pop);
  assign drop   = bus.sample_valid & ~push;
  assign accept = txv_q & bus.tx_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    seq_d   = seq_q;
    seqr_d  = seqr_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          seqr_d  = seq_q;
          seq_d   = seq_q + 8'd1;
          state_d = S_HDR;
        end
      end
      default: begin
        if (accept)
          state_d = (state_q == S_CSUM) ? S_IDLE
                  : state_e'(state_q + 3'd1);
      end
    endcase
  end

  // Byte is registered from the next state so a stall re-selects it.
  always_comb begin
    txv_d = (state_d != S_IDLE);
    txd_d = txd_q;
    unique case (state_d)
      S_IDLE: txd_d = txd_q;
      S_HDR:  txd_d = HEADER;
      S_SEQ:  txd_d = seqr_q;
      S_D3:   txd_d = word_q[31:24];
      S_D2:   txd_d = word_q[23:16];
      S_D1:   txd_d = word_q[15:8];
      S_D0:   txd_d = word_q[7:0];
      S_CSUM: txd_d = csum8(seqr_q, word_q);
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      seq_q   <= '0;
      seqr_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      seq_q   <= seq_d;
      seqr_q  <= seqr_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.tx_data   = txd_q;
  assign bus.tx_valid  = txv_q;
  assign overflow_o    = ovf_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with a
// byte scoreboard fed when samples are driven.
module tb_adc_frame_packer;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear_ovf;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  adc_frame_packer_if bus();

  adc_frame_packer dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .fifo_level_o (fifo_level),
    .overflow_o   (overflow),
    .drop_count_o (drop_count),
    .clear_ovf_i  (clear_ovf)
  );

  always #5 clock = ~clock;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seq_m = 8'd0;
  logic [31:0] d;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq_m);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(seq_m ^ w[31:24] ^ w[23:16]
                    ^ w[15:8] ^ w[7:0]);
    seq_m = seq_m + 8'd1;
  endtask

  // Drive one cycle's inputs at the falling edge and
  // score the byte that the next rising edge accepts.
  task automatic cycle(
    input logic        sv,
    input logic [31:0] sd,
    input logic        rdy,
    input logic        clr
  );
    @(negedge clock);
    bus.sample_valid = sv;
    bus.sample_data  = sd;
    bus.tx_ready     = rdy;
    clear_ovf        = clr;
    if (bus.tx_valid === 1'b1 && rdy) begin
      if (exp_q.size() == 0)
        chk("extra_byte", 32'(exp_q.size()), 32'd1);
      else
        chk("tx_byte", bus.tx_data, exp_q.pop_front());
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (n < max && (exp_q.size() != 0 ||
           bus.tx_valid === 1'b1 || fifo_level != 0)) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    clear_ovf        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.tx_ready     = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_valid", bus.tx_valid, 1'b0);
    chk("rst_data", bus.tx_data, 8'h00);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_count, 8'd0);
    reset = 1'b0;

    // single frame, ready held high
    d = 32'h12345678;
    cycle(1'b1, d, 1'b1, 1'b0);
    push_frame(d);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t1_lat_c1", bus.tx_valid, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("t1_valid", bus.tx_valid, 1'b1);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t1_gap", bus.tx_valid, 1'b0);
    chk("t1_sb", 32'(exp_q.size()), 32'd0);

    // back-pressure on D2
    cycle(1'b1, d, 1'b1, 1'b0);
    push_frame(d);
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (5) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      chk("t2_hold_v", bus.tx_valid, 1'b1);
      chk("t2_hold_d", bus.tx_data, 8'h34);
    end
    drain(20);

    // burst of 10 with ready low: 9 kept, 1 dropped
    for (int i = 0; i < 10; i++) begin
      d = 32'hA0B0_0000 + 32'(i);
      cycle(1'b1, d, 1'b0, 1'b0);
      if (i < 9) push_frame(d);
      if (i == 9) begin
        chk("t3_lvl9", fifo_level, 4'd8);
        chk("t3_ovf9", overflow, 1'b0);
      end
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t3_lvl", fifo_level, 4'd8);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_drop", drop_count, 8'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_clr_ovf", overflow, 1'b0);
    chk("t6_clr_drop", drop_count, 8'd0);
    drain(200);

    // clear coincident with a drop, then saturation
    for (int i = 0; i < 9; i++) begin
      d = 32'h5500_0000 + 32'(i * 7);
      cycle(1'b1, d, 1'b0, 1'b0);
      push_frame(d);
    end
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_drop2", drop_count, 8'd2);
    chk("t6_full", fifo_level, 4'd8);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_coin_ovf", overflow, 1'b1);
    chk("t6_coin_drop", drop_count, 8'd1);
    repeat (260) cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_sat", drop_count, 8'hFF);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_clr2_ovf", overflow, 1'b0);
    chk("t6_clr2_drop", drop_count, 8'd0);
    drain(200);

    // async reset during D1 with a word queued
    d = 32'hDEADBEEF;
    cycle(1'b1, d, 1'b1, 1'b0);
    push_frame(d);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0BADF00D, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t5_d1", bus.tx_data, 8'hBE);
    chk("t5_lvl_pre", fifo_level, 4'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", bus.tx_valid, 1'b0);
    chk("t5_data", bus.tx_data, 8'h00);
    chk("t5_lvl", fifo_level, 4'd0);
    exp_q.delete();
    seq_m = 8'd0;
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    reset = 1'b0;
    d = 32'h00C0FFEE;
    cycle(1'b1, d, 1'b1, 1'b0);
    push_frame(d);
    drain(30);

    // 257 back-to-back frames: SEQ wraps FF -> 00
    for (int f = 0; f < 257; f++) begin
      d = $urandom;
      cycle(1'b1, d, 1'b1, 1'b0);
      push_frame(d);
      repeat (7) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    end
    drain(60);
    chk("t4_seq_next", seq_m, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
